// File: rtl/frame_packet_reset_ctrl_if.sv
// frame_packet_reset_ctrl_if: stream/control bundle between the sync/receiver chain and the frame/packet reset controller
//   Providing_Stream, input_strobe  : stream framing from the synchroniser
//   frames_per_pak, timeout_cycles  : runtime packet length and stall limit
//   force_reset                     : request for an immediate reset pulse
//   s_RST_OUT                       : reset to the downstream chain
//   frame_done, pak_done, frame_cnt : frame/packet progress
//   timeout_flag                    : stall watchdog expiry pulse
interface frame_packet_reset_ctrl_if #(
   parameter int CNT_W     = 4,
   parameter int TIMEOUT_W = 16
);
   logic                 Providing_Stream;
   logic                 input_strobe;
   logic [CNT_W-1:0]     frames_per_pak;
   logic [TIMEOUT_W-1:0] timeout_cycles;
   logic                 force_reset;
   logic                 s_RST_OUT;
   logic                 frame_done;
   logic                 pak_done;
   logic [CNT_W-1:0]     frame_cnt;
   logic                 timeout_flag;
   modport master (
      output Providing_Stream, input_strobe, frames_per_pak, timeout_cycles, force_reset,
      input  s_RST_OUT, frame_done, pak_done, frame_cnt, timeout_flag
   );
   modport slave (
      input  Providing_Stream, input_strobe, frames_per_pak, timeout_cycles, force_reset,
      output s_RST_OUT, frame_done, pak_done, frame_cnt, timeout_flag
   );
endinterface

// File: rtl/frame_packet_reset_ctrl.sv
// frame_packet_reset_ctrl: counts frames into packets and issues a multi-cycle downstream reset at packet end, stall timeout or on request
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset (also forces s_RST_OUT high)
//   bus : slave side of frame_packet_reset_ctrl_if (stream inputs, packet config, progress and reset outputs)
module frame_packet_reset_ctrl #(
   parameter int CNT_W       = 4,
   parameter int RST_PULSE_W = 2,
   parameter int PULSE_CNT_W = 3,
   parameter int TIMEOUT_W   = 16
) (
   input logic                     CLK,
   input logic                     RST,
   frame_packet_reset_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FRAME, RST_HOLD} state_t;
   localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(RST_PULSE_W - 1);
   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n, eff_len;
   logic [CNT_W:0]         cnt_inc;
   logic [TIMEOUT_W-1:0]   wd, wd_n, wd_inc;
   logic [PULSE_CNT_W-1:0] pcnt, pcnt_n;
   logic                   hold, hold_n, fd, fd_n, pd, pd_n, to, to_n;
   logic                   pak_end, expire;
   assign eff_len = (bus.frames_per_pak == '0) ? CNT_W'(1) : bus.frames_per_pak;
   // one extra bit so a shortened packet length still compares correctly
   assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
   assign pak_end = cnt_inc >= {1'b0, eff_len};
   assign wd_inc  = wd + TIMEOUT_W'(1);
   assign expire  = (bus.timeout_cycles != '0) && (wd_inc >= bus.timeout_cycles);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wd_n    = '0;
      pcnt_n  = pcnt;
      hold_n  = hold;
      fd_n    = 1'b0;
      pd_n    = 1'b0;
      to_n    = 1'b0;
      if (bus.force_reset) begin
         state_n = RST_HOLD;
         cnt_n   = '0;
         pcnt_n  = '0;
         hold_n  = 1'b1;
      end else begin
         case (state)
            IDLE: state_n = (bus.input_strobe && bus.Providing_Stream) ? FRAME : IDLE;
            FRAME: begin
               if (!bus.Providing_Stream) begin
                  fd_n    = 1'b1;
                  pd_n    = pak_end;
                  cnt_n   = pak_end ? '0 : cnt_inc[CNT_W-1:0];
                  state_n = pak_end ? RST_HOLD : IDLE;
                  pcnt_n  = '0;
                  hold_n  = pak_end;
               end else if (!bus.input_strobe && expire) begin
                  to_n    = 1'b1;
                  cnt_n   = '0;
                  state_n = RST_HOLD;
                  pcnt_n  = '0;
                  hold_n  = 1'b1;
               end else begin
                  wd_n = bus.input_strobe ? '0 : wd_inc;
               end
            end
            RST_HOLD: begin
               // hold was raised on the entry edge, so the last count value drops it
               hold_n  = pcnt != PULSE_LAST;
               state_n = (pcnt == PULSE_LAST) ? IDLE : RST_HOLD;
               pcnt_n  = (pcnt == PULSE_LAST) ? '0 : pcnt + PULSE_CNT_W'(1);
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               pcnt_n  = '0;
               hold_n  = 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         wd    <= '0;
         pcnt  <= '0;
         hold  <= 1'b0;
         fd    <= 1'b0;
         pd    <= 1'b0;
         to    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         wd    <= wd_n;
         pcnt  <= pcnt_n;
         hold  <= hold_n;
         fd    <= fd_n;
         pd    <= pd_n;
         to    <= to_n;
      end
   end
   assign bus.s_RST_OUT    = hold | RST;
   assign bus.frame_done   = fd;
   assign bus.pak_done     = pd;
   assign bus.frame_cnt    = cnt;
   assign bus.timeout_flag = to;
endmodule

// File: tb/tb_frame_packet_reset_ctrl.sv
// tb_frame_packet_reset_ctrl: directed bench with a cycle-level behavioural model and literal spot checks
module tb_frame_packet_reset_ctrl;
   localparam int W = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0, checks = 0;
   int   m_in_frame = 0, m_frames = 0, m_stall = 0, m_hold = 0, m_len = 1;
   int   m_fd = 0, m_pd = 0, m_to = 0;
   int   n_fd = 0, n_pd = 0, n_to = 0, n_rhi = 0;
   int   s_fd, s_pd, s_to, s_rhi;
   frame_packet_reset_ctrl_if bus ();
   frame_packet_reset_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // model: hold_left counts remaining reset cycles; frames/stall are plain integers
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_in_frame = 0; m_frames = 0; m_stall = 0; m_hold = 0;
         m_fd = 0; m_pd = 0; m_to = 0;
      end else begin
         m_fd = 0; m_pd = 0; m_to = 0;
         m_len = (bus.frames_per_pak == 0) ? 1 : int'(bus.frames_per_pak);
         if (bus.force_reset) begin
            m_frames = 0; m_stall = 0; m_in_frame = 0; m_hold = W;
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (!m_in_frame) begin
            m_stall = 0;
            if (bus.input_strobe && bus.Providing_Stream) m_in_frame = 1;
         end else if (!bus.Providing_Stream) begin
            m_fd = 1;
            m_in_frame = 0;
            if (m_frames + 1 >= m_len) begin
               m_pd = 1; m_frames = 0; m_hold = W;
            end else m_frames++;
         end else if (bus.input_strobe) begin
            m_stall = 0;
         end else begin
            m_stall++;
            if (bus.timeout_cycles != 0 && m_stall >= int'(bus.timeout_cycles)) begin
               m_to = 1; m_frames = 0; m_hold = W; m_in_frame = 0;
            end
         end
      end
   end
   always @(negedge clk) begin
      chk("s_RST_OUT", int'(bus.s_RST_OUT), int'(m_hold > 0 || rst));
      chk("frame_done", int'(bus.frame_done), m_fd);
      chk("pak_done", int'(bus.pak_done), m_pd);
      chk("timeout_flag", int'(bus.timeout_flag), m_to);
      chk("frame_cnt", int'(bus.frame_cnt), m_frames % 16);
      n_fd += int'(bus.frame_done);
      n_pd += int'(bus.pak_done);
      n_to += int'(bus.timeout_flag);
      n_rhi += int'(bus.s_RST_OUT);
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic frame(input int len);
      bus.Providing_Stream = 1'b1;
      bus.input_strobe = 1'b1;
      cyc(len);
      bus.Providing_Stream = 1'b0;
      bus.input_strobe = 1'b0;
      cyc(1);
   endtask
   task automatic snap();
      s_fd = n_fd; s_pd = n_pd; s_to = n_to; s_rhi = n_rhi;
   endtask
   task automatic force_clear();
      bus.force_reset = 1'b1;
      cyc(1);
      bus.force_reset = 1'b0;
      cyc(3);
   endtask
   initial begin
      bus.Providing_Stream = 1'b0;
      bus.input_strobe = 1'b0;
      bus.frames_per_pak = 4'd4;
      bus.timeout_cycles = '0;
      bus.force_reset = 1'b0;
      #1 rst = 1'b1;
      cyc(2);
      chk("reset_rst_out", int'(bus.s_RST_OUT), 1);
      chk("reset_cnt", int'(bus.frame_cnt), 0);
      rst = 1'b0;
      cyc(1);
      chk("release_rst_out", int'(bus.s_RST_OUT), 0);
      // four-frame packet
      snap();
      for (int i = 1; i <= 4; i++) begin
         frame(10);
         chk("pak4_cnt", int'(bus.frame_cnt), i % 4);
         cyc(3);
      end
      chk("pak4_fd", n_fd - s_fd, 4);
      chk("pak4_pd", n_pd - s_pd, 1);
      chk("pak4_rhi", n_rhi - s_rhi, 2);
      // zero length acts as one
      bus.frames_per_pak = 4'd0;
      snap();
      frame(10);
      chk("len0_cnt", int'(bus.frame_cnt), 0);
      chk("len0_pd", int'(bus.pak_done), 1);
      cyc(3);
      frame(5);
      cyc(3);
      chk("len0_fd", n_fd - s_fd, 2);
      chk("len0_pdn", n_pd - s_pd, 2);
      chk("len0_rhi", n_rhi - s_rhi, 4);
      // stall watchdog
      bus.frames_per_pak = 4'd4;
      bus.timeout_cycles = 16'd5;
      frame(10);
      cyc(3);
      chk("wd_pre_cnt", int'(bus.frame_cnt), 1);
      snap();
      bus.Providing_Stream = 1'b1;
      bus.input_strobe = 1'b1;
      cyc(3);
      bus.input_strobe = 1'b0;
      cyc(4);
      chk("wd_early", int'(bus.timeout_flag), 0);
      cyc(1);
      chk("wd_flag", int'(bus.timeout_flag), 1);
      chk("wd_cnt", int'(bus.frame_cnt), 0);
      chk("wd_rst_out", int'(bus.s_RST_OUT), 1);
      bus.Providing_Stream = 1'b0;
      cyc(3);
      chk("wd_fd", n_fd - s_fd, 0);
      chk("wd_to", n_to - s_to, 1);
      chk("wd_rhi", n_rhi - s_rhi, 2);
      bus.timeout_cycles = '0;
      snap();
      bus.Providing_Stream = 1'b1;
      bus.input_strobe = 1'b1;
      cyc(3);
      bus.input_strobe = 1'b0;
      cyc(20);
      bus.Providing_Stream = 1'b0;
      cyc(1);
      chk("nowd_fd", int'(bus.frame_done), 1);
      chk("nowd_cnt", int'(bus.frame_cnt), 1);
      cyc(3);
      chk("nowd_to", n_to - s_to, 0);
      // force_reset on the packet-ending edge
      force_clear();
      for (int i = 0; i < 3; i++) begin
         frame(10);
         cyc(3);
      end
      chk("force_pre_cnt", int'(bus.frame_cnt), 3);
      bus.Providing_Stream = 1'b1;
      bus.input_strobe = 1'b1;
      cyc(10);
      snap();
      bus.Providing_Stream = 1'b0;
      bus.input_strobe = 1'b0;
      bus.force_reset = 1'b1;
      cyc(1);
      bus.force_reset = 1'b0;
      chk("force_fd", int'(bus.frame_done), 0);
      chk("force_pd", int'(bus.pak_done), 0);
      chk("force_cnt", int'(bus.frame_cnt), 0);
      chk("force_rst_out", int'(bus.s_RST_OUT), 1);
      cyc(3);
      chk("force_rhi", n_rhi - s_rhi, 2);
      chk("force_pdn", n_pd - s_pd, 0);
      // retrigger inside the hold
      snap();
      bus.force_reset = 1'b1;
      cyc(1);
      bus.force_reset = 1'b0;
      cyc(1);
      bus.force_reset = 1'b1;
      cyc(1);
      bus.force_reset = 1'b0;
      cyc(1);
      chk("retrig_hold", int'(bus.s_RST_OUT), 1);
      cyc(1);
      chk("retrig_end", int'(bus.s_RST_OUT), 0);
      chk("retrig_rhi", n_rhi - s_rhi, 4);
      // async reset mid-frame
      frame(10);
      cyc(3);
      frame(10);
      cyc(3);
      chk("rst_pre_cnt", int'(bus.frame_cnt), 2);
      bus.Providing_Stream = 1'b1;
      bus.input_strobe = 1'b1;
      cyc(3);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_out", int'(bus.s_RST_OUT), 1);
      chk("rst_mid_cnt", int'(bus.frame_cnt), 0);
      bus.Providing_Stream = 1'b0;
      bus.input_strobe = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("rst_rel_out", int'(bus.s_RST_OUT), 0);
      frame(10);
      chk("rst_next_cnt", int'(bus.frame_cnt), 1);
      cyc(3);
      // async reset mid-hold aborts the pulse
      bus.force_reset = 1'b1;
      cyc(1);
      bus.force_reset = 1'b0;
      chk("hold_rst_pre", int'(bus.s_RST_OUT), 1);
      #1 rst = 1'b1;
      #1;
      chk("hold_rst_out", int'(bus.s_RST_OUT), 1);
      cyc(1);
      rst = 1'b0;
      #1;
      chk("hold_abort", int'(bus.s_RST_OUT), 0);
      cyc(2);
      // packet length lowered below the current count
      force_clear();
      for (int i = 0; i < 3; i++) begin
         frame(10);
         cyc(3);
      end
      chk("shrink_pre_cnt", int'(bus.frame_cnt), 3);
      bus.frames_per_pak = 4'd2;
      frame(10);
      chk("shrink_pd", int'(bus.pak_done), 1);
      chk("shrink_cnt", int'(bus.frame_cnt), 0);
      cyc(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_packet_reset_ctrl.md
Name: frame_packet_reset_ctrl

Overview:
Parametrised successor to the single-count sync resetter in the sync/receiver integration path.
- Tracks frames delimited by Providing_Stream and input_strobe.
- Counts frames against a runtime packet length.
- Issues a registered, multi-cycle reset pulse to the synchroniser/receiver chain at packet end, on stall timeout, or on request.
- Exposes frame/packet progress for the receiver controller.

Parameters:
CNT_W, 4, width of the frame counter and of frames_per_pak
RST_PULSE_W, 2, cycles s_RST_OUT is held by the block (min 1)
PULSE_CNT_W, 3, width of the pulse-length counter (2^PULSE_CNT_W > RST_PULSE_W)
TIMEOUT_W, 16, width of the stall watchdog counter and of timeout_cycles

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-high reset
Providing_Stream  in  1  high while the synchroniser delivers a frame
input_strobe  in  1  sample-valid strobe
frames_per_pak  in  CNT_W  frames per packet; 0 is treated as 1
timeout_cycles  in  TIMEOUT_W  stall limit in cycles; 0 disables the watchdog
force_reset  in  1  synchronous request for an immediate reset pulse
s_RST_OUT  out  1  reset to downstream: reset_hold register OR RST
frame_done  out  1  one-cycle pulse per completed frame
pak_done  out  1  one-cycle pulse when the last frame of a packet completes
frame_cnt  out  CNT_W  frames completed in the current packet
timeout_flag  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- RST asserted (async): state=IDLE, frame_cnt=0, watchdog=0, pulse counter=0, reset_hold=0, all pulses=0. s_RST_OUT=1 combinationally while RST is high.
- States: IDLE, FRAME, RST_HOLD. Every output except s_RST_OUT is registered.
- IDLE -> FRAME when input_strobe & Providing_Stream are sampled high.
- FRAME, Providing_Stream sampled low (frame end):
  - frame_done=1 next cycle.
  - If frame_cnt+1 >= eff_len (eff_len = max(frames_per_pak,1), sampled at this edge): pak_done=1, frame_cnt<=0, state<=RST_HOLD.
  - Otherwise frame_cnt<=frame_cnt+1, state<=IDLE.
- FRAME watchdog:
  - Increments on each cycle with input_strobe low; clears to 0 on strobe.
  - When timeout_cycles != 0 and the count reaches timeout_cycles: timeout_flag=1, frame_cnt<=0, state<=RST_HOLD, no frame_done.
  - Watchdog clears on leaving FRAME.
- RST_HOLD:
  - reset_hold=1 for exactly RST_PULSE_W cycles, starting the cycle after entry (same cycle as pak_done/timeout_flag).
  - Then reset_hold=0 and state=IDLE.
  - Stream inputs are ignored in this state.
- force_reset sampled high in any state:
  - frame_cnt<=0, watchdog<=0, state<=RST_HOLD, pulse counter restarts (pulse retriggers if already in RST_HOLD).
  - frame_done, pak_done and timeout_flag are suppressed that edge.
- Priority at one edge: force_reset > frame end > watchdog expiry. Frame end and expiry together counts as a frame end.
- frames_per_pak changed mid-packet: takes effect at the next frame end. If frame_cnt already >= new eff_len, the next frame end completes the packet.
- frame_cnt never wraps. It only reaches eff_len-1 before clearing.
- RST asserted mid-RST_HOLD: pulse aborted, all state to reset values. s_RST_OUT stays high through RST, then falls once RST deasserts.

Test Plan:
- frames_per_pak=4, 4 frames (each: strobe+stream high for 10 cycles, stream low) -> frame_done x4, frame_cnt 1,2,3,0, pak_done with the 4th, s_RST_OUT high for 2 cycles.
- frames_per_pak=0, 1 frame -> pak_done plus reset pulse after every frame, frame_cnt stays 0.
- timeout_cycles=5, stream high, strobe stops after 3 cycles -> timeout_flag exactly 5 cycles later, frame_cnt=0, 2-cycle reset, no frame_done. Repeat with timeout_cycles=0 -> no timeout.
- force_reset on the same edge as the 4th frame end -> no frame_done/pak_done, single 2-cycle pulse. force_reset during RST_HOLD -> pulse extended to 2 cycles from retrigger.
- RST asserted mid-frame with frame_cnt=2 and mid-RST_HOLD -> s_RST_OUT high immediately, frame_cnt=0. After release, IDLE; the next frame counts as 1.
- frames_per_pak lowered from 4 to 2 when frame_cnt=3 -> next frame end gives pak_done and frame_cnt=0.
